// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU; one transaction in flight.
// Define ALU_ARB_FIXED_PRIORITY_EN to make requester 0 win every tie instead of round-robin.
//
// state | meaning
// IDLE  | waiting for a request; ready raised for the granted requester
// EXEC  | registered operands drive the ALU; result captured at end of cycle
// RESP  | response held for the served requester until it is consumed
module alu_arbiter #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0_valid_i,
  output logic          req0_ready_o,
  input  logic [DW-1:0] req0_a_i,
  input  logic [DW-1:0] req0_b_i,
  input  logic [2:0]    req0_op_i,
  input  logic          req1_valid_i,
  output logic          req1_ready_o,
  input  logic [DW-1:0] req1_a_i,
  input  logic [DW-1:0] req1_b_i,
  input  logic [2:0]    req1_op_i,
  output logic          rsp0_valid_o,
  input  logic          rsp0_ready_i,
  output logic [DW-1:0] rsp0_data_o,
  output logic          rsp0_err_o,
  output logic          rsp1_valid_o,
  input  logic          rsp1_ready_i,
  output logic [DW-1:0] rsp1_data_o,
  output logic          rsp1_err_o,
  output logic [DW-1:0] alu_a_o,
  output logic [DW-1:0] alu_b_o,
  output logic [2:0]    alu_op_o,
  input  logic [DW-1:0] alu_res_i,
  output logic [15:0]   ops_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            gnt0, gnt1;
  logic            sel_q;
  logic            err_q;
  logic [DW-1:0]   a_q, b_q, res_q;
  logic [2:0]      op_q;
  logic [15:0]     ops_cnt_q;
  logic            rsp_hs;

`ifdef ALU_ARB_FIXED_PRIORITY_EN
  assign gnt1 = req1_valid_i & ~req0_valid_i;
`else
  logic last_q;
  // On a tie requester 1 wins only when requester 0 was served last.
  assign gnt1 = req1_valid_i & (~req0_valid_i | ~last_q);
`endif
  assign gnt0 = req0_valid_i & ~gnt1;

  assign rsp_hs    = (state_q == RESP) & (sel_q ? rsp1_ready_i : rsp0_ready_i);
  assign ops_cnt_o = ops_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    alu_a_o      = '0;
    alu_b_o      = '0;
    alu_op_o     = '0;
    rsp0_valid_o = 1'b0;
    rsp1_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        // Gate with reset so the ready outputs stay low while reset is held.
        req0_ready_o = gnt0 & reset_n;
        req1_ready_o = gnt1 & reset_n;
        if (gnt0 | gnt1) state_d = EXEC;
      end
      EXEC: begin
        alu_a_o  = a_q;
        alu_b_o  = b_q;
        alu_op_o = op_q;
        state_d  = RESP;
      end
      RESP: begin
        rsp0_valid_o = ~sel_q;
        rsp1_valid_o = sel_q;
        if (rsp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rsp0_data_o = rsp0_valid_o ? res_q : '0;
    rsp1_data_o = rsp1_valid_o ? res_q : '0;
    rsp0_err_o  = rsp0_valid_o & err_q;
    rsp1_err_o  = rsp1_valid_o & err_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      sel_q     <= 1'b0;
      res_q     <= '0;
      err_q     <= 1'b0;
      ops_cnt_q <= '0;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
      last_q    <= 1'b1;
`endif
    end else begin
      if ((state_q == IDLE) && (gnt0 | gnt1)) begin
        a_q   <= gnt1 ? req1_a_i  : req0_a_i;
        b_q   <= gnt1 ? req1_b_i  : req0_b_i;
        op_q  <= gnt1 ? req1_op_i : req0_op_i;
        sel_q <= gnt1;
      end
      if (state_q == EXEC) begin
        err_q <= (op_q == 3'd7);
        res_q <= (op_q == 3'd7) ? '0 : alu_res_i;
      end
      if (rsp_hs) begin
        ops_cnt_q <= ops_cnt_q + 16'd1;
`ifndef ALU_ARB_FIXED_PRIORITY_EN
        last_q    <= sel_q;
`endif
      end
    end
  end

endmodule
